// File: rtl/clk_gen_multi_if.sv
// clk_gen_multi_if: groups the per-channel control inputs and divided-clock outputs of clk_gen_multi.
// Ports (signals): en, sync, div_load, div_in, mode_in (master -> slave); clk_out, tick, pend (slave -> master).
// Modports: master = controller / testbench side, slave = clk_gen_multi side.
interface clk_gen_multi_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32
);
  logic [N_CH-1:0]       en;
  logic                  sync;
  logic [N_CH-1:0]       div_load;
  logic [N_CH*CNT_W-1:0] div_in;
  logic [N_CH-1:0]       mode_in;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       pend;

  modport master (
    output en, sync, div_load, div_in, mode_in,
    input  clk_out, tick, pend
  );

  modport slave (
    input  en, sync, div_load, div_in, mode_in,
    output clk_out, tick, pend
  );
endinterface

// File: rtl/clk_gen_multi.sv
// clk_gen_multi: N_CH independent programmable dividers, each producing a 50% toggle clock or a one-cycle tick.
// Ports: clk, rst (sync, active-high); bus (slave): en/sync/div_load/div_in/mode_in in, clk_out/tick/pend out.
// Latency: all outputs registered; tick appears the cycle after the terminal edge. No backpressure.
module clk_gen_multi #(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 32,
  parameter int DEF_DIV = 5
) (
  input  logic           clk,
  input  logic           rst,
  clk_gen_multi_if.slave bus
);

  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE_W     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q    [N_CH];
  logic [CNT_W-1:0] cnt_d    [N_CH];
  logic [CNT_W-1:0] div_q    [N_CH];
  logic [CNT_W-1:0] div_d    [N_CH];
  logic [CNT_W-1:0] shd_div_q[N_CH];
  logic [CNT_W-1:0] shd_div_d[N_CH];
  logic [N_CH-1:0]  mode_q, mode_d;         // 0 = toggle, 1 = pulse
  logic [N_CH-1:0]  shd_mode_q, shd_mode_d;
  logic [N_CH-1:0]  clk_q, clk_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic [N_CH-1:0]  pend_q, pend_d;

  // A zero divisor behaves as divide-by-one.
  function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
    return (d == '0) ? ONE_W : d;
  endfunction

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    shd_div_d  = shd_div_q;
    mode_d     = mode_q;
    shd_mode_d = shd_mode_q;
    clk_d      = clk_q;
    pend_d     = pend_q;
    tick_d     = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.sync) begin
        // Restart all channels together; a load arriving now bypasses the shadow wait.
        cnt_d[k] = '0;
        if (bus.div_load[k]) begin
          div_d[k]      = bus.div_in[k*CNT_W +: CNT_W];
          mode_d[k]     = bus.mode_in[k];
          shd_div_d[k]  = bus.div_in[k*CNT_W +: CNT_W];
          shd_mode_d[k] = bus.mode_in[k];
          pend_d[k]     = 1'b0;
        end else if (pend_q[k]) begin
          div_d[k]  = shd_div_q[k];
          mode_d[k] = shd_mode_q[k];
          pend_d[k] = 1'b0;
        end
      end else if (bus.div_load[k] && !bus.en[k]) begin
        // Idle channel: nothing to disturb, so take the new setting immediately.
        cnt_d[k]      = '0;
        div_d[k]      = bus.div_in[k*CNT_W +: CNT_W];
        mode_d[k]     = bus.mode_in[k];
        shd_div_d[k]  = bus.div_in[k*CNT_W +: CNT_W];
        shd_mode_d[k] = bus.mode_in[k];
        pend_d[k]     = 1'b0;
      end else if (bus.en[k]) begin
        // '>=' keeps a channel from running away if the counter ever sits above the limit.
        if (cnt_q[k] >= eff_div(div_q[k]) - ONE_W) begin
          cnt_d[k] = '0;
          // The terminal edge itself still obeys the old mode.
          if (mode_q[k]) tick_d[k] = 1'b1;
          else           clk_d[k]  = ~clk_q[k];
          if (bus.div_load[k]) begin
            div_d[k]      = bus.div_in[k*CNT_W +: CNT_W];
            mode_d[k]     = bus.mode_in[k];
            shd_div_d[k]  = bus.div_in[k*CNT_W +: CNT_W];
            shd_mode_d[k] = bus.mode_in[k];
            pend_d[k]     = 1'b0;
          end else if (pend_q[k]) begin
            div_d[k]  = shd_div_q[k];
            mode_d[k] = shd_mode_q[k];
            pend_d[k] = 1'b0;
          end
        end else begin
          cnt_d[k] = cnt_q[k] + ONE_W;
          if (bus.div_load[k]) begin
            shd_div_d[k]  = bus.div_in[k*CNT_W +: CNT_W];
            shd_mode_d[k] = bus.mode_in[k];
            pend_d[k]     = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        cnt_q[k]     <= '0;
        div_q[k]     <= DEF_DIV_W;
        shd_div_q[k] <= DEF_DIV_W;
      end
      mode_q     <= '0;
      shd_mode_q <= '0;
      clk_q      <= '0;
      tick_q     <= '0;
      pend_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      shd_div_q  <= shd_div_d;
      mode_q     <= mode_d;
      shd_mode_q <= shd_mode_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      pend_q     <= pend_d;
    end
  end

  assign bus.clk_out = clk_q;
  assign bus.tick    = tick_q;
  assign bus.pend    = pend_q;

endmodule

// File: doc/clk_gen_multi.md
CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

Interface
REQ-001 The block SHALL have parameter N_CH, default 2, meaning number of independent divider channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning width of each channel's counter and divisor.
REQ-003 The block SHALL have parameter DEF_DIV, default 5, meaning divisor loaded into every channel at reset (1 .. 2^CNT_W-1).
REQ-004 The block SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port en  input  N_CH  per-channel count enable.
REQ-007 The block SHALL have port sync  input  1  restarts all channel counters together.
REQ-008 The block SHALL have port div_load  input  N_CH  per-channel request to load a new divisor and mode.
REQ-009 The block SHALL have port div_in  input  N_CH*CNT_W  new divisors; channel k uses bits [k*CNT_W +: CNT_W].
REQ-010 The block SHALL have port mode_in  input  N_CH  new mode per channel: 0 = toggle, 1 = pulse.
REQ-011 The block SHALL have port clk_out  output  N_CH  toggle-mode square wave per channel, registered.
REQ-012 The block SHALL have port tick  output  N_CH  single-cycle terminal-count strobe per channel, registered.
REQ-013 The block SHALL have port pend  output  N_CH  high while a loaded divisor/mode waits to take effect.

Function
REQ-014 Each channel SHALL hold an active divisor D, active mode M, shadow divisor, shadow mode, a CNT_W-bit counter, and pend, all independent of other channels.
REQ-015 An effective divisor SHALL be used: D_eff = 1 when D = 0, else D.
REQ-016 On a clock edge with en[k]=1 and sync=0, if counter = D_eff-1 the counter SHALL go to 0 (terminal event), else increment by 1.
REQ-017 On a terminal event in toggle mode, clk_out[k] SHALL invert, giving a period of 2*D_eff cycles at 50% duty; tick[k] SHALL stay 0.
REQ-018 On a terminal event in pulse mode, tick[k] SHALL be 1 for exactly the following cycle, giving one tick every D_eff enabled cycles; clk_out[k] SHALL hold its value.
REQ-019 tick[k] SHALL be 0 in every cycle not immediately following a terminal event.
REQ-020 With en[k]=0, the counter and clk_out[k] SHALL hold, and tick[k] SHALL be 0.
REQ-021 div_load[k]=1 SHALL capture div_in slice and mode_in[k] into the shadow registers and set pend[k] on the same edge; a later load before commit SHALL overwrite the shadow.
REQ-022 While pend[k]=1, the shadow SHALL be committed to D/M at the next terminal event or next sync edge, and pend[k] SHALL clear on that same edge.
REQ-023 If en[k]=0 when div_load[k]=1, the commit SHALL occur on the same edge: the counter is set to 0 and pend[k] stays 0.
REQ-024 The terminal event that commits SHALL still act under the old mode; the new D/M SHALL govern from the next count onward.
REQ-025 sync=1 SHALL set every counter to 0, commit any pending shadows, clear tick, and leave clk_out unchanged, regardless of en.
REQ-026 When div_load[k] and sync are high together, the new div_in/mode_in values SHALL be committed directly and pend[k] SHALL remain 0.
REQ-027 When div_load[k] coincides with a terminal event, the terminal event SHALL act under the old D/M, and the new values SHALL be committed on that same edge with pend[k] left 0.
REQ-028 Switching from toggle to pulse SHALL freeze clk_out[k] at its current level; switching from pulse to toggle SHALL resume toggling from that level.
REQ-029 The counter SHALL never exceed D_eff-1 after any commit: if it is already >= the new D_eff-1, the next enabled edge SHALL be a terminal event.

Reset
REQ-030 On a clock edge with rst=1, every channel SHALL set counter=0, D=DEF_DIV, M=toggle, shadow=DEF_DIV/toggle, clk_out=0, tick=0, pend=0.
REQ-031 rst SHALL take priority over sync, div_load and en; reset asserted mid-period SHALL discard any partial count and pending load.

Verification
REQ-032 Reset, en=all 1, DEF_DIV=5, toggle -> clk_out[0] rises after edge 5, falls after edge 10, period 10 cycles, tick stays 0.
REQ-033 Ch1 load D=3 mode=pulse while en[1]=0, then en[1]=1 -> tick[1] high one cycle after every 3rd enabled edge, clk_out[1] frozen at 0.
REQ-034 Ch0 running D=5, load D=2 at count 1 -> pend[0]=1 until the edge where count reaches 4, then pend=0 and half-period becomes 2.
REQ-035 Load D=0 pulse -> tick high every cycle (D_eff=1); en toggled low for 3 cycles -> tick 0 and counter frozen for exactly those cycles.
REQ-036 Two channels at D=4 and D=6 desynchronised, pulse sync -> both counters 0 next cycle, next ticks after 4 and 6 edges respectively; rst asserted with sync and div_load -> all state at reset values.
